// File: rtl/lcd1602_pkg.sv
// Shared types and constants for the LCD1602 8-bit write-only driver.
package lcd1602_pkg;

  localparam int unsigned LINE_LEN  = 16;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned INIT_CMDS = 4;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_INIT  = 3'd1,
    S_IDLE  = 3'd2,
    S_ADDR1 = 3'd3,
    S_LINE1 = 3'd4,
    S_ADDR2 = 3'd5,
    S_LINE2 = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2
  } phase_t;

  // One byte as presented on the panel bus: register select plus DB7..DB0.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic lcd_byte_t cmd_byte(input logic [7:0] code);
    lcd_byte_t b;
    b.rs   = 1'b0;
    b.data = code;
    return b;
  endfunction

  function automatic lcd_byte_t init_cmd(input logic [1:0] idx);
    lcd_byte_t b;
    case (idx)
      2'd0:    b = cmd_byte(FUNC_SET);
      2'd1:    b = cmd_byte(DISP_ON);
      2'd2:    b = cmd_byte(ENTRY_MODE);
      default: b = cmd_byte(CLEAR);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd1602_writer_if.sv
// Host-side buffer port plus LCD pin bundle for lcd1602_writer.
interface lcd1602_writer_if;
  import lcd1602_pkg::*;

  logic              frame_req;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              lcd_en;
  logic [7:0]        lcd_data;
  logic              init_done;
  logic              busy;
  logic              frame_done;

  // Host / character buffer side.
  modport master (
    output frame_req, char_data,
    input  char_addr, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, busy, frame_done
  );

  // Writer side.
  modport slave (
    input  frame_req, char_data,
    output char_addr, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, busy, frame_done
  );
endinterface

// File: rtl/lcd1602_tick.sv
// Free-running divider producing a one-clock step tick every TICK_DIV clocks.
module lcd1602_tick #(
  parameter int unsigned TICK_DIV = 96000
) (
  input  logic clk_48M,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  logic [CNT_W-1:0] count_q;

  assign tick_c = (count_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk_48M or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (tick_c) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lcd1602_writer.sv
// HD44780/LCD1602 8-bit write-only driver: power-up init, then 2x16 frames from a buffer.
// Optional build macro LCD1602_AUTO_REFRESH_EN: repeat frames forever, ignore frame_req.
module lcd1602_writer
  import lcd1602_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 96000,
  parameter int unsigned POWERUP_TICKS = 20
) (
  input  logic               clk_48M,
  input  logic               rst,
  lcd1602_writer_if.slave    bus
);

  localparam int unsigned PWR_W = (POWERUP_TICKS < 2) ? 1 : $clog2(POWERUP_TICKS + 1);

  logic              tick_c;
  logic              req_any;
  lcd_byte_t         cur_byte;

  state_t            state_q,     state_d;
  phase_t            phase_q,     phase_d;
  logic [PWR_W-1:0]  pwr_cnt_q,   pwr_cnt_d;
  logic [1:0]        init_idx_q,  init_idx_d;
  logic              pending_q,   pending_d;
  logic [ADDR_W-1:0] char_addr_q, char_addr_d;
  logic              lcd_rs_q,    lcd_rs_d;
  logic [7:0]        lcd_data_q,  lcd_data_d;
  logic              lcd_en_q,    lcd_en_d;
  logic              init_done_q, init_done_d;
  logic              busy_q,      busy_d;
  logic              frame_done_q, frame_done_d;

  lcd1602_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_48M (clk_48M),
    .rst     (rst),
    .tick_c  (tick_c)
  );

`ifdef LCD1602_AUTO_REFRESH_EN
  logic unused_frame_req;
  assign unused_frame_req = bus.frame_req;
  assign req_any          = 1'b1;
`else
  // A request seen this very cycle counts, so a pulse during S_DONE chains the next frame.
  assign req_any = pending_q | bus.frame_req;
`endif

  // Byte that the current byte-transfer state puts on the bus at P0.
  always_comb begin
    cur_byte = cmd_byte(8'h00);
    case (state_q)
      S_INIT:           cur_byte = init_cmd(init_idx_q);
      S_ADDR1:          cur_byte = cmd_byte(LINE1_ADDR);
      S_ADDR2:          cur_byte = cmd_byte(LINE2_ADDR);
      S_LINE1, S_LINE2: begin
        cur_byte.rs   = 1'b1;
        cur_byte.data = bus.char_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pwr_cnt_d    = pwr_cnt_q;
    init_idx_d   = init_idx_q;
    char_addr_d  = char_addr_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    lcd_en_d     = lcd_en_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_PWR: begin
        if (tick_c) begin
          if (pwr_cnt_q == PWR_W'(POWERUP_TICKS - 1)) begin
            state_d = S_INIT;
            phase_d = PH_0;
          end else begin
            pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
          end
        end
      end

      S_IDLE: begin
        if (tick_c && req_any) begin
          state_d = S_ADDR1;
        end
      end

      // Lasts one clock only, so a chained frame loses no tick.
      S_DONE: begin
        state_d = req_any ? S_ADDR1 : S_IDLE;
      end

      default: begin
        if (tick_c) begin
          case (phase_q)
            PH_0: begin
              lcd_rs_d   = cur_byte.rs;
              lcd_data_d = cur_byte.data;
              lcd_en_d   = 1'b0;
              phase_d    = PH_1;
            end
            PH_1: begin
              lcd_en_d = 1'b1;
              phase_d  = PH_2;
            end
            default: begin
              lcd_en_d = 1'b0;
              phase_d  = PH_0;
              case (state_q)
                S_INIT: begin
                  if (init_idx_q == 2'(INIT_CMDS - 1)) begin
                    init_done_d = 1'b1;
                    state_d     = req_any ? S_ADDR1 : S_IDLE;
                  end else begin
                    init_idx_d = init_idx_q + 2'd1;
                  end
                end
                S_ADDR1: begin
                  char_addr_d = '0;
                  state_d     = S_LINE1;
                end
                S_LINE1: begin
                  if (char_addr_q == ADDR_W'(LINE_LEN - 1)) begin
                    state_d = S_ADDR2;
                  end else begin
                    char_addr_d = char_addr_q + ADDR_W'(1);
                  end
                end
                S_ADDR2: begin
                  char_addr_d = ADDR_W'(LINE_LEN);
                  state_d     = S_LINE2;
                end
                S_LINE2: begin
                  if (char_addr_q == ADDR_W'(2 * LINE_LEN - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_DONE;
                  end else begin
                    char_addr_d = char_addr_q + ADDR_W'(1);
                  end
                end
                default: ;
              endcase
            end
          endcase
        end
      end
    endcase

`ifdef LCD1602_AUTO_REFRESH_EN
    pending_d = 1'b0;
    busy_d    = 1'b1;
`else
    // Pending is consumed when a frame starts; extra requests collapse into it.
    if (state_d == S_ADDR1 && state_q != S_ADDR1) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q | bus.frame_req;
    end
    busy_d = (state_d != S_IDLE) || pending_d;
`endif
  end

  always_ff @(posedge clk_48M or negedge rst) begin
    if (!rst) begin
      state_q      <= S_PWR;
      phase_q      <= PH_0;
      pwr_cnt_q    <= '0;
      init_idx_q   <= '0;
      pending_q    <= 1'b0;
      char_addr_q  <= '0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      lcd_en_q     <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pwr_cnt_q    <= pwr_cnt_d;
      init_idx_q   <= init_idx_d;
      pending_q    <= pending_d;
      char_addr_q  <= char_addr_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      lcd_en_q     <= lcd_en_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.char_addr  = char_addr_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = lcd_en_q;
  assign bus.lcd_data   = lcd_data_q;
  assign bus.init_done  = init_done_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd1602_writer.sv
// Scoreboard bench for lcd1602_writer: expected panel bytes queued at stimulus time, checked per lcd_en pulse.
module tb_lcd1602_writer;
  import lcd1602_pkg::*;

  localparam int unsigned TD = 4;
  localparam int unsigned PT = 2;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [1:0] kind;   // 0 plain, 1 last init byte, 2 last frame byte
    logic [1:0] gap;    // 0 free, 1 back-to-back with previous byte, 2 first byte after reset
  } exp_t;

  logic clk_48M = 1'b0;
  logic rst     = 1'b0;

  lcd1602_writer_if bus ();

  lcd1602_writer #(.TICK_DIV(TD), .POWERUP_TICKS(PT)) dut (
    .clk_48M (clk_48M),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_48M = ~clk_48M;

  logic [7:0] char_mem [32];
  assign bus.char_data = char_mem[bus.char_addr];

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0, since_rst = 0, last_rise = 0, pops = 0, frames_done = 0, due = 0;
  logic [1:0] due_kind = 2'd0;
  logic prev_en = 1'b0, prev_init_done = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: panel byte sequences straight from the command/frame definition.
  task automatic push_init();
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{rs: 1'b0, data: cmds[i], kind: (i == 3) ? 2'd1 : 2'd0,
                        gap: (i == 0) ? 2'd2 : 2'd1});
  endtask

  task automatic push_frame(input bit contig);
    exp_t e;
    for (int n = 0; n < 34; n++) begin
      if (n == 0)       begin e.rs = 1'b0; e.data = 8'h80; end
      else if (n <= 16) begin e.rs = 1'b1; e.data = char_mem[n - 1]; end
      else if (n == 17) begin e.rs = 1'b0; e.data = 8'hC0; end
      else              begin e.rs = 1'b1; e.data = char_mem[n - 2]; end
      e.kind = (n == 33) ? 2'd2 : 2'd0;
      e.gap  = (n == 0) ? (contig ? 2'd1 : 2'd0) : 2'd1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one comparison per lcd_en rising edge, plus init_done/frame_done timing.
  always @(negedge clk_48M) begin
    logic fd_exp;
    cyc++;
    fd_exp = 1'b0;
    if (!rst) begin
      since_rst = 0;
      prev_en   = 1'b0;
      due       = 0;
    end else begin
      since_rst++;
      if (due > 0) begin
        due--;
        if (due == 0) begin
          if (due_kind == 2'd2) begin
            fd_exp = 1'b1;
            frames_done++;
          end else begin
            check("init_done_rise", 32'({prev_init_done, bus.init_done}), 32'h1);
          end
        end
      end
      if (bus.frame_done || fd_exp)
        check("frame_done_pulse", 32'(bus.frame_done), 32'(fd_exp));
      if (bus.lcd_en && !prev_en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_en_pulse: got rs=%0b data=0x%0h, expected no pulse (t=%0t)",
                   bus.lcd_rs, bus.lcd_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("lcd_byte", 32'({bus.lcd_rw, bus.lcd_rs, bus.lcd_data}), 32'({1'b0, mon_e.rs, mon_e.data}));
          if (mon_e.gap == 2'd1) check("en_spacing", 32'(cyc - last_rise), 32'(3 * TD));
          if (mon_e.gap == 2'd2) check("first_en_time", 32'(since_rst), 32'((PT + 2) * TD));
          if (mon_e.kind != 2'd0) begin
            due      = TD;
            due_kind = mon_e.kind;
          end
        end
        pops++;
        last_rise = cyc;
      end
      prev_en        = bus.lcd_en;
      prev_init_done = bus.init_done;
    end
  end

  task automatic step();
    @(negedge clk_48M);
    #1;
  endtask

  task automatic pulse_req();
    bus.frame_req = 1'b1;
    step();
    bus.frame_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || due != 0) && n < budget) begin
      step();
      n++;
    end
    check("queue_drained", 32'(exp_q.size() + due), 32'h0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) char_mem[i] = 8'($urandom);
  endtask

  task automatic check_reset_values();
    check("rst_lcd_en",     32'(bus.lcd_en),     32'h0);
    check("rst_lcd_rs",     32'(bus.lcd_rs),     32'h0);
    check("rst_lcd_rw",     32'(bus.lcd_rw),     32'h0);
    check("rst_lcd_data",   32'(bus.lcd_data),   32'h0);
    check("rst_char_addr",  32'(bus.char_addr),  32'h0);
    check("rst_init_done",  32'(bus.init_done),  32'h0);
    check("rst_busy",       32'(bus.busy),       32'h1);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, target, n;
    bit dropped;
    bus.frame_req = 1'b0;
    for (int i = 0; i < 32; i++) char_mem[i] = 8'(8'h41 + i);
    rst = 1'b0;
    repeat (3) step();
    check_reset_values();

`ifdef LCD1602_AUTO_REFRESH_EN
    push_init();
    for (int f = 0; f < 3; f++) push_frame(1'b1);
    rst = 1'b1;
    wait_drain(2000);
    check("auto_frames", 32'(frames_done), 32'd3);
    check("auto_busy", 32'(bus.busy), 32'h1);
`else
    // Reset release, no request.
    push_init();
    rst = 1'b1;
    wait_drain(300);
    check("init_done_level", 32'(bus.init_done), 32'h1);
    repeat (2) step();
    check("idle_busy", 32'(bus.busy), 32'h0);

    // One request in idle, 0x41+addr buffer.
    push_frame(1'b0);
    pulse_req();
    check("req_busy", 32'(bus.busy), 32'h1);
    wait_drain(800);
    repeat (2) step();
    check("after_frame_busy", 32'(bus.busy), 32'h0);

    // Three requests mid-frame collapse into one follow-on frame.
    randomize_mem();
    push_frame(1'b0);
    push_frame(1'b1);
    base = pops;
    pulse_req();
    target = base + $urandom_range(3, 20);
    n = 0;
    while (pops < target && n < 500) begin step(); n++; end
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 12)) step();
      pulse_req();
    end
    wait_drain(1600);
    repeat (2) step();
    check("collapse_busy", 32'(bus.busy), 32'h0);

    // Request coincident with S_DONE chains the next frame with no gap.
    randomize_mem();
    push_frame(1'b0);
    pulse_req();
    n = 0;
    while (!bus.frame_done && n < 800) begin step(); n++; end
    check("saw_frame_done", 32'(bus.frame_done), 32'h1);
    push_frame(1'b1);
    pulse_req();
    wait_drain(800);

    // Reset while lcd_en is high in line 1, then request during re-init.
    randomize_mem();
    push_frame(1'b0);
    base = pops;
    pulse_req();
    target = base + 1 + $urandom_range(1, 14);
    n = 0;
    while (!(pops >= target && bus.lcd_en) && n < 500) begin step(); n++; end
    check("en_high_before_rst", 32'(bus.lcd_en), 32'h1);
    rst = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    repeat (3) step();
    push_init();
    base = pops;
    rst = 1'b1;
    dropped = 1'b0;
    n = 0;
    while (pops == base && n < 100) begin step(); n++; end
    check("reinit_started", 32'(pops - base), 32'h1);
    push_frame(1'b1);
    pulse_req();
    n = 0;
    while ((exp_q.size() != 0 || due != 0) && n < 800) begin
      step();
      n++;
      if (!bus.busy) dropped = 1'b1;
    end
    check("queue_drained_reinit", 32'(exp_q.size() + due), 32'h0);
    check("busy_held_through_init", 32'(dropped), 32'h0);
    check("reinit_done", 32'(bus.init_done), 32'h1);
    repeat (2) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
